// File: rtl/write_skid_buffer_fifo.sv
// Show-ahead FIFO: a 2-entry write-side skid register stage feeding a DEPTH-entry array (capacity DEPTH+2).
// Define KANAGAWA_WRITE_SKID_FIFO_ASSERT_EN to elaborate simulation-only consistency assertions.
module write_skid_buffer_fifo #(
  parameter int DEPTH              = 32,
  parameter int WIDTH              = 32,
  parameter int ALMOSTFULL_ENTRIES = 0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             overflow_out,
  input  logic             rdreq,
  output logic             empty,
  output logic [WIDTH-1:0] q,
  output logic             underflow_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 3);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_AT = CW'(DEPTH + 2 - ALMOSTFULL_ENTRIES);

  logic [WIDTH-1:0] skid0_q, skid0_d, skid1_q, skid1_d;
  logic [1:0]       skid_cnt_q, skid_cnt_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    arr_cnt_q, arr_cnt_d;
  logic             full_q, full_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             accept, xfer, rd_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    empty  = (arr_cnt_q == '0);
    accept = wrreq & ~full_q;
    // Transfer looks only at registered counts so wrreq/rdreq never reach the array side.
    xfer   = (skid_cnt_q != 2'd0) && (arr_cnt_q < DEPTH_C);
    rd_ok  = rdreq & ~empty;

    skid0_d    = skid0_q;
    skid1_d    = skid1_q;
    skid_cnt_d = skid_cnt_q;
    if (xfer) begin
      skid0_d    = skid1_q;
      skid_cnt_d = skid_cnt_q - 2'd1;
    end
    if (accept) begin
      if (skid_cnt_d == 2'd0) skid0_d = data;
      else                    skid1_d = data;
      skid_cnt_d = skid_cnt_d + 2'd1;
    end

    wr_ptr_d  = xfer  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = rd_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    arr_cnt_d = arr_cnt_q + CW'(xfer) - CW'(rd_ok);

    full_d = (skid_cnt_d == 2'd2) || ((CW'(skid_cnt_d) + arr_cnt_d) >= FULL_AT);
    ovf_d  = wrreq & full_q;
    unf_d  = rdreq & empty;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      skid_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      arr_cnt_q  <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      skid_cnt_q <= skid_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      arr_cnt_q  <= arr_cnt_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_ff @(posedge clock) begin
    skid0_q <= skid0_d;
    skid1_q <= skid1_d;
    if (xfer && !rst) mem_q[wr_ptr_q] <= skid0_q;
  end

  assign full          = full_q;
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;
  assign q             = mem_q[rd_ptr_q];

`ifdef KANAGAWA_WRITE_SKID_FIFO_ASSERT_EN
  always_ff @(posedge clock) begin
    if (!rst) begin
      assert (!(wrreq && full_q))            else $error("write_skid_buffer_fifo: write while full");
      assert (!(rdreq && empty))             else $error("write_skid_buffer_fifo: read while empty");
      assert (skid_cnt_q <= 2'd2)            else $error("write_skid_buffer_fifo: skid count > 2");
      assert (arr_cnt_q <= DEPTH_C)          else $error("write_skid_buffer_fifo: array count > DEPTH");
      assert (empty == (arr_cnt_q == '0))    else $error("write_skid_buffer_fifo: empty disagrees with count");
      assert (!(skid_cnt_q == 2'd2 && !full_q)) else $error("write_skid_buffer_fifo: skid full but full low");
    end
  end
`endif

endmodule

// File: tb/tb_write_skid_buffer_fifo.sv
// Bench for write_skid_buffer_fifo: three parameterisations checked against a word-queue reference model.
module tb_write_skid_buffer_fifo;

  logic        clock = 1'b0;
  logic        wr [3];
  logic        rd [3];
  logic        rs [3];
  logic [31:0] din [3];
  logic        full_o [3];
  logic        empty_o [3];
  logic        ovf_o [3];
  logic        unf_o [3];
  logic [31:0] q_o [3];

  int tests = 0;
  int fails = 0;

  int dtab [3] = '{4, 8, 5};
  int atab [3] = '{0, 3, 0};

  // Reference: all stored words in order; the first m_arr of them are in the array.
  logic [31:0] mq [$];
  int          m_arr  = 0;
  bit          m_full = 0;
  bit          m_ovf  = 0;
  bit          m_unf  = 0;
  int          popped = 0;

  always #5 clock = ~clock;

  write_skid_buffer_fifo #(.DEPTH(4), .WIDTH(32), .ALMOSTFULL_ENTRIES(0)) u_d4 (
    .clock(clock), .rst(rs[0]), .wrreq(wr[0]), .data(din[0]), .full(full_o[0]),
    .overflow_out(ovf_o[0]), .rdreq(rd[0]), .empty(empty_o[0]), .q(q_o[0]),
    .underflow_out(unf_o[0]));

  write_skid_buffer_fifo #(.DEPTH(8), .WIDTH(32), .ALMOSTFULL_ENTRIES(3)) u_d8 (
    .clock(clock), .rst(rs[1]), .wrreq(wr[1]), .data(din[1]), .full(full_o[1]),
    .overflow_out(ovf_o[1]), .rdreq(rd[1]), .empty(empty_o[1]), .q(q_o[1]),
    .underflow_out(unf_o[1]));

  write_skid_buffer_fifo #(.DEPTH(5), .WIDTH(32), .ALMOSTFULL_ENTRIES(0)) u_d5 (
    .clock(clock), .rst(rs[2]), .wrreq(wr[2]), .data(din[2]), .full(full_o[2]),
    .overflow_out(ovf_o[2]), .rdreq(rd[2]), .empty(empty_o[2]), .q(q_o[2]),
    .underflow_out(unf_o[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock for instance i: drive, advance the model by the capacity rules, then compare.
  task automatic step(input int i, input bit w, input logic [31:0] d, input bit r, input bit rst_in);
    int  dep, af, skid_n;
    bit  acc, xf, rok;
    dep = dtab[i];
    af  = atab[i];
    wr[i] = w; din[i] = d; rd[i] = r; rs[i] = rst_in;
    skid_n = mq.size() - m_arr;
    acc = w && !m_full;
    xf  = (skid_n > 0) && (m_arr < dep);
    rok = r && (m_arr > 0);
    if (!rst_in && rok) chk("q_at_pop", q_o[i], mq[0]);
    @(posedge clock);
    #1;
    wr[i] = 1'b0; rd[i] = 1'b0; rs[i] = 1'b0;
    if (rst_in) begin
      mq.delete();
      m_arr = 0; m_full = 0; m_ovf = 0; m_unf = 0;
    end else begin
      m_ovf = w && m_full;
      m_unf = r && (m_arr == 0);
      if (rok) begin
        void'(mq.pop_front());
        popped++;
      end
      m_arr = m_arr + int'(xf) - int'(rok);
      if (acc) mq.push_back(d);
      skid_n = mq.size() - m_arr;
      m_full = (skid_n == 2) || (mq.size() >= dep + 2 - af);
    end
    chk("full", 32'(full_o[i]), 32'(m_full));
    chk("empty", 32'(empty_o[i]), 32'(m_arr == 0));
    chk("overflow", 32'(ovf_o[i]), 32'(m_ovf));
    chk("underflow", 32'(unf_o[i]), 32'(m_unf));
    if (m_arr > 0) chk("q_head", q_o[i], mq[0]);
  endtask

  initial begin
    int cyc;
    int pushed;
    bit phase_w;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 1'b0; rd[i] = 1'b0; rs[i] = 1'b0; din[i] = '0;
    end
    @(posedge clock);

    // Fill without reads, DEPTH=4
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) step(0, 1, 32'(k), 0, 0);
    chk("fill_full", 32'(full_o[0]), 32'd1);
    step(0, 1, 32'hDEAD, 0, 0);
    chk("ovf_pulse", 32'(ovf_o[0]), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("ovf_clear", 32'(ovf_o[0]), 32'd0);
    for (int k = 1; k <= 6; k++) step(0, 0, 0, 1, 0);
    chk("drain_empty", 32'(empty_o[0]), 32'd1);
    step(0, 0, 0, 1, 0);
    chk("unf_pulse", 32'(unf_o[0]), 32'd1);

    // Streaming, DEPTH=4
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) step(0, 1, 32'(k), m_arr > 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 0, m_arr > 0, 0);
    chk("stream_drained", 32'(popped), 32'd26);

    // Almost-full, DEPTH=8 ALMOSTFULL_ENTRIES=3
    step(1, 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) step(1, 1, $urandom, 0, 0);
    chk("af_full", 32'(full_o[1]), 32'd1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("af_release", 32'(full_o[1]), 32'd0);

    // Wrap-around, DEPTH=5, random bursts
    step(2, 0, 0, 0, 1);
    popped = 0; pushed = 0; cyc = 0; phase_w = 1;
    while (popped < 23 && cyc < 2000) begin
      bit w, r;
      if ($urandom_range(0, 5) == 0) phase_w = ~phase_w;
      w = (pushed < 23) && !m_full && (phase_w ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      r = (m_arr > 0) && (phase_w ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      if (w) pushed++;
      step(2, w, $urandom, r, 0);
      cyc++;
    end
    chk("wrap_done", 32'(popped), 32'd23);

    // Reset mid-operation, DEPTH=4
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) step(0, 1, 32'hA0 + 32'(k), 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32'h55, 1, 1);
    chk("rst_empty", 32'(empty_o[0]), 32'd1);
    chk("rst_full", 32'(full_o[0]), 32'd0);
    step(0, 1, 32'h77, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_q", q_o[0], 32'h77);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_after_empty", 32'(empty_o[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
